// File: rtl/mem_dst_writer.sv
// rtl/mem_dst_writer.sv - destination endpoint: address reassembly, one-stage write pipeline, 32-entry memory
// Optional build macro MEM_DST_SEQ_CHECK_EN enables expected-address sequence checking.
module mem_dst_writer #(
    parameter int DATA_W     = 8,
    parameter int FIRST_ADDR = 1,
    parameter int LAST_ADDR  = 19
) (
    input  logic              clk,
    input  logic              rstor,
    input  logic              in1,
    input  logic              in2,
    input  logic              in3,
    input  logic              in4,
    input  logic              in5,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [5:0]        word_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [4:0]        addr;
    logic              accept;
    logic              seq_ok;
    logic              capture;
    logic              last_write;
    logic [DATA_W-1:0] mem [32];

    assign addr       = {in1, in2, in3, in4, in5};
    assign last_write = wr_en && (wr_addr == 5'(LAST_ADDR));
    assign capture    = accept && seq_ok;

`ifdef MEM_DST_SEQ_CHECK_EN
    logic [4:0] exp_addr;
    logic       err_q;

    assign seq_ok = (addr == exp_addr);
    assign err    = err_q;

    // A rejected word neither writes nor advances the expected address.
    always_ff @(posedge clk) begin
        if (rstor) begin
            exp_addr <= 5'(FIRST_ADDR);
            err_q    <= 1'b0;
        end else begin
            if (capture) begin
                exp_addr <= exp_addr + 5'd1;
            end
            if (accept && !seq_ok) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_first_addr;

    assign seq_ok            = 1'b1;
    assign err               = 1'b0;
    assign unused_first_addr = ^FIRST_ADDR;
`endif

    always_ff @(posedge clk) begin
        if (rstor) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    accept   = 1'b1;
                    state_nx = RECV;
                end
            end
            RECV: begin
                accept = din_valid;
                if (last_write) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                accept = 1'b0;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // A word captured on the same edge that reaches DONE still drains.
    assign busy = (state == RECV) || ((state == DONE) && wr_en);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rstor) begin
            wr_en    <= 1'b0;
            wr_addr  <= 5'd0;
            wr_data  <= '0;
            word_cnt <= 6'd0;
        end else begin
            wr_en <= capture;
            if (capture) begin
                wr_addr <= addr;
                wr_data <= din;
            end
            if (wr_en && (word_cnt != 6'd63)) begin
                word_cnt <= word_cnt + 6'd1;
            end
        end
    end

    // Memory is never cleared; reset only blocks a write pending on that edge.
    always_ff @(posedge clk) begin
        if (wr_en && !rstor) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rstor) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_mem_dst_writer.sv
// tb/tb_mem_dst_writer.sv - self-checking bench for mem_dst_writer against a transaction-level model
module tb_mem_dst_writer;

    localparam int LAST = 19;
    localparam int FIRST = 1;

    logic       clk = 1'b0;
    logic       rstor = 1'b1;
    logic       in1 = 1'b0, in2 = 1'b0, in3 = 1'b0, in4 = 1'b0, in5 = 1'b0;
    logic [7:0] din = 8'd0;
    logic       din_valid = 1'b0;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] word_cnt;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;

    // Reference model: a word either lands in memory or is dropped, decided at acceptance.
    logic [7:0] m_mem [32];
    bit         m_known [32];
    int         m_cnt = 0;
    bit         m_done = 0;
    bit         m_err = 0;
    int         m_exp = FIRST;

    mem_dst_writer dut (
        .clk(clk), .rstor(rstor),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
        .din(din), .din_valid(din_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .word_cnt(word_cnt),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_accept(input int a, input logic [7:0] d);
        if (m_done) return 1'b0;
`ifdef MEM_DST_SEQ_CHECK_EN
        if (a != m_exp) begin
            m_err = 1'b1;
            return 1'b0;
        end
        m_exp = m_exp + 1;
`endif
        m_mem[a]   = d;
        m_known[a] = 1'b1;
        if (m_cnt < 63) m_cnt++;
        if (a == LAST) m_done = 1'b1;
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_cnt  = 0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_exp  = FIRST;
    endtask

    task automatic cycle(input bit v, input int a, input logic [7:0] d);
        bit exp_wr;
        {in1, in2, in3, in4, in5} = 5'(a);
        din       = d;
        din_valid = v;
        exp_wr    = v ? m_accept(a, d) : 1'b0;
        @(posedge clk); #1;
        din_valid = 1'b0;
        chk("wr_en", 32'(wr_en), 32'(exp_wr));
        if (exp_wr) begin
            chk("wr_addr", 32'(wr_addr), 32'(a));
            chk("wr_data", 32'(wr_data), 32'(d));
        end
        wr_pulses += int'(wr_en);
    endtask

    task automatic do_reset();
        rstor     = 1'b1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        rstor = 1'b0;
        m_reset();
    endtask

    task automatic rd(input int a, input string tag);
        rd_addr = 5'(a);
        @(posedge clk); #1;
        chk(tag, 32'(rd_data), 32'(m_mem[a]));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
        chk({tag, "_word_cnt"}, 32'(word_cnt), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] old;
        bit         oldk;
        int         nxt;
        int         n;

        // Reset state
        rstor = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rstor = 1'b0;
        m_reset();

        // Normal transfer, back-to-back
        wr_pulses = 0;
        for (int a = 1; a <= LAST; a++) begin
            cycle(1'b1, a, 8'(a + 8'hA0));
            if (a == 1) chk("busy_mid", 32'(busy), 1);
        end
        chk("done_not_yet", 32'(done), 0);
        cycle(1'b0, 0, 8'h00);
        chk("done_normal", 32'(done), 1);
        chk("busy_normal", 32'(busy), 0);
        chk("cnt_normal", 32'(word_cnt), 19);
        chk("pulses_normal", 32'(wr_pulses), 19);
        rd(5, "rd5_model");
        chk("rd5_const", 32'(rd_data), 32'hA5);

        // Post-done input is ignored
        cycle(1'b1, 3, 8'hFF);
        cycle(1'b0, 0, 8'h00);
        chk("postdone_cnt", 32'(word_cnt), 19);
        rd(3, "postdone_rd3");
        chk("postdone_rd3_const", 32'(rd_data), 32'hA3);

        // Gapped valid
        do_reset();
        wr_pulses = 0;
        for (int a = 1; a <= LAST; a++) begin
            cycle(1'b1, a, 8'(a + 8'hA0));
            cycle(1'b0, 0, 8'h00);
        end
        chk("gap_cnt", 32'(word_cnt), 19);
        chk("gap_done", 32'(done), 1);
        chk("gap_pulses", 32'(wr_pulses), 19);
        for (int a = 1; a <= LAST; a++) rd(a, "gap_mem");

        // Reset mid-transfer
        do_reset();
        for (int a = 1; a <= 6; a++) cycle(1'b1, a, 8'($urandom));
        old  = m_mem[7];
        oldk = m_known[7];
        cycle(1'b1, 7, 8'($urandom));
        rstor = 1'b1;
        @(posedge clk); #1;
        m_mem[7]   = old;
        m_known[7] = oldk;
        m_reset();
        chk_all_zero("midreset");
        rstor = 1'b0;
        for (int a = 1; a <= 7; a++) rd(a, "midreset_mem");
        for (int a = 1; a <= LAST; a++) cycle(1'b1, a, 8'($urandom));
        cycle(1'b0, 0, 8'h00);
        chk("restart_done", 32'(done), 1);
        chk("restart_cnt", 32'(word_cnt), 19);

        // Read/write collision on address 9
        do_reset();
        for (int a = 1; a <= 8; a++) cycle(1'b1, a, 8'($urandom));
        old = m_mem[9];
        d   = 8'($urandom);
        if (d == old) d = ~d;
        rd_addr = 5'd9;
        cycle(1'b1, 9, d);
        cycle(1'b0, 0, 8'h00);
        chk("collide_old", 32'(rd_data), 32'(old));
        cycle(1'b0, 0, 8'h00);
        chk("collide_new", 32'(rd_data), 32'(d));

        // Sequence error: 1, 2, 4 then 3
        do_reset();
        cycle(1'b1, 1, 8'($urandom));
        cycle(1'b1, 2, 8'($urandom));
        d = ~m_mem[4];
        cycle(1'b1, 4, d);
        cycle(1'b0, 0, 8'h00);
        chk("seq_cnt", 32'(word_cnt), 32'(m_cnt));
        chk("seq_err", 32'(err), 32'(m_err));
        rd(4, "seq_mem4");
        cycle(1'b1, 3, 8'($urandom));
        cycle(1'b0, 0, 8'h00);
        chk("seq_cnt3", 32'(word_cnt), 32'(m_cnt));
        chk("seq_err3", 32'(err), 32'(m_err));
        rd(3, "seq_mem3");

        // Random addresses below LAST: exercises word_cnt saturation
        do_reset();
        for (int i = 0; i < 90; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, LAST - 1), 8'($urandom));
        cycle(1'b0, 0, 8'h00);
        chk("sat_cnt", 32'(word_cnt), 32'(m_cnt));
        chk("sat_err", 32'(err), 32'(m_err));

        // Random transfers with gaps and occasional stray addresses
        for (int t = 0; t < 3; t++) begin
            do_reset();
            nxt = FIRST;
            n   = 0;
            while (!m_done && n < 200) begin
                bit v;
                int a;
                v = ($urandom_range(0, 3) != 0);
                a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : nxt;
                cycle(v, a, 8'($urandom));
                if (v && a == nxt && nxt < LAST) nxt++;
                n++;
            end
            cycle(1'b0, 0, 8'h00);
            chk("rnd_done", 32'(done), 32'(m_done));
            chk("rnd_busy", 32'(busy), 32'(!m_done));
            chk("rnd_cnt", 32'(word_cnt), 32'(m_cnt));
            chk("rnd_err", 32'(err), 32'(m_err));
            for (int a = 0; a < 32; a++)
                if (m_known[a]) rd(a, "rnd_mem");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
